// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch direction memory:
// direction codes, default code width and the init FSM state encoding.
package nw_pkg;

   localparam int DIR_W_DEF = 3;

   localparam logic [2:0] DIR_STOP = 3'b000;
   localparam logic [2:0] DIR_DIAG = 3'b001;
   localparam logic [2:0] DIR_UP   = 3'b010;
   localparam logic [2:0] DIR_LEFT = 3'b100;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_INIT_ROW = 2'd1,
      ST_INIT_COL = 2'd2,
      ST_READY    = 2'd3
   } state_t;

endpackage

// File: rtl/dir_mem_1w1r.sv
// Plain synchronous memory: one write port, one registered read port.
// A read and write to the same address in one cycle returns the old data.
module dir_mem_1w1r #(
   parameter int DEPTH = 16,
   parameter int AW    = 4,
   parameter int W     = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem_r [DEPTH];
   logic [W-1:0] rdata_r;

   // Storage array: no reset, contents undefined until written.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Read data register: captures on a read strobe, holds otherwise.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata_r <= '0;
      end else if (re) begin
         rdata_r <= mem_r[raddr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/direction_ram_ctrl.sv
// Direction memory controller for a (LEN_A+1)x(LEN_B+1) traceback matrix.
// Sequences the gap row/column initialisation, range-checks the fill write
// port and the traceback read port, and flags rejected accesses.
// Optional build macro: RD_FWD_EN selects write-first forwarding on a
// same-cycle read/write to one cell; without it reads return old data.
module direction_ram_ctrl
   import nw_pkg::*;
#(
   parameter int LEN_A = 128,
   parameter int LEN_B = 128,
   parameter int DIR_W = DIR_W_DEF,
   parameter int IW    = $clog2(LEN_A + 1),
   parameter int JW    = $clog2(LEN_B + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_init,
   output logic             busy,
   output logic             ready,
   output logic             init_done,
   input  logic             wr_en,
   input  logic [IW-1:0]    wr_i,
   input  logic [JW-1:0]    wr_j,
   input  logic [DIR_W-1:0] wr_dir,
   input  logic             rd_en,
   input  logic [IW-1:0]    rd_i,
   input  logic [JW-1:0]    rd_j,
   output logic [DIR_W-1:0] rd_dir,
   output logic             rd_valid,
   output logic             err_oob
);

   localparam int DEPTH = (LEN_A + 1) * (LEN_B + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = (IW > JW) ? IW : JW;

   state_t           state_r, state_s;
   logic [CW-1:0]    cnt_r, cnt_s;
   logic             busy_r, ready_r, init_done_r, rd_valid_r, err_oob_r;
   logic             init_we_s;
   logic [AW-1:0]    init_addr_s;
   logic [DIR_W-1:0] init_data_s;
   logic             start_acc_s, wr_ok_s, rd_ok_s, bad_s;
   logic             mem_we_s;
   logic [AW-1:0]    mem_waddr_s, wr_addr_s, rd_addr_s;
   logic [DIR_W-1:0] mem_wdata_s, mem_q_s;

   function automatic logic [AW-1:0] cell_addr(input logic [IW-1:0] i,
                                                input logic [JW-1:0] j);
      cell_addr = AW'(i) * AW'(LEN_B + 1) + AW'(j);
   endfunction

   assign start_acc_s = start_init && ((state_r == ST_IDLE) || (state_r == ST_READY));
   assign wr_addr_s   = cell_addr(wr_i, wr_j);
   assign rd_addr_s   = cell_addr(rd_i, rd_j);
   assign wr_ok_s     = ready_r && wr_en && (wr_i >= IW'(1)) && (wr_i <= IW'(LEN_A))
                        && (wr_j >= JW'(1)) && (wr_j <= JW'(LEN_B));
   assign rd_ok_s     = ready_r && rd_en && (rd_i <= IW'(LEN_A)) && (rd_j <= JW'(LEN_B));
   assign bad_s       = (wr_en && !wr_ok_s) || (rd_en && !rd_ok_s);

   // Init sequencer: next state, counter and border write generation.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      init_we_s   = 1'b0;
      init_addr_s = '0;
      init_data_s = '0;
      case (state_r)
         ST_IDLE, ST_READY: begin
            if (start_init) begin
               state_s = ST_INIT_ROW;
               cnt_s   = '0;
            end else begin
               state_s = state_r;
            end
         end
         ST_INIT_ROW: begin
            init_we_s   = 1'b1;
            init_addr_s = AW'(cnt_r);
            init_data_s = (cnt_r == '0) ? DIR_W'(DIR_STOP) : DIR_W'(DIR_LEFT);
            if (cnt_r == CW'(LEN_B)) begin
               cnt_s   = CW'(1);
               state_s = ST_INIT_COL;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         ST_INIT_COL: begin
            init_we_s   = 1'b1;
            init_addr_s = cell_addr(IW'(cnt_r), '0);
            init_data_s = DIR_W'(DIR_UP);
            if (cnt_r == CW'(LEN_A)) begin
               cnt_s   = '0;
               state_s = ST_READY;
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
            cnt_s   = '0;
         end
      endcase
   end

   // Memory write port arbitration: border writes during init, fill writes when ready.
   always_comb begin
      mem_we_s = init_we_s || wr_ok_s;
      if (init_we_s) begin
         mem_waddr_s = init_addr_s;
         mem_wdata_s = init_data_s;
      end else begin
         mem_waddr_s = wr_addr_s;
         mem_wdata_s = wr_dir;
      end
   end

   // State, counter and registered status/handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         busy_r      <= 1'b0;
         ready_r     <= 1'b0;
         init_done_r <= 1'b0;
         rd_valid_r  <= 1'b0;
         err_oob_r   <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         busy_r      <= (state_s == ST_INIT_ROW) || (state_s == ST_INIT_COL);
         ready_r     <= (state_s == ST_READY);
         init_done_r <= (state_s == ST_READY) && (state_r != ST_READY);
         rd_valid_r  <= rd_ok_s;
         if (start_acc_s) begin
            err_oob_r <= 1'b0;
         end else if (bad_s) begin
            err_oob_r <= 1'b1;
         end else begin
            err_oob_r <= err_oob_r;
         end
      end
   end

   dir_mem_1w1r #(
      .DEPTH(DEPTH),
      .AW   (AW),
      .W    (DIR_W)
   ) u_mem (
      .clk  (clk),
      .rst  (rst),
      .we   (mem_we_s),
      .waddr(mem_waddr_s),
      .wdata(mem_wdata_s),
      .re   (rd_ok_s),
      .raddr(rd_addr_s),
      .rdata(mem_q_s)
   );

`ifdef RD_FWD_EN
   logic             fwd_hit_r;
   logic [DIR_W-1:0] fwd_data_r;

   // Forwarding capture: remember whether the accepted read collided with a write.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fwd_hit_r  <= 1'b0;
         fwd_data_r <= '0;
      end else if (rd_ok_s) begin
         fwd_hit_r  <= wr_ok_s && (wr_addr_s == rd_addr_s);
         fwd_data_r <= wr_dir;
      end else begin
         fwd_hit_r  <= fwd_hit_r;
         fwd_data_r <= fwd_data_r;
      end
   end

   assign rd_dir = fwd_hit_r ? fwd_data_r : mem_q_s;
`else
   assign rd_dir = mem_q_s;
`endif

   assign busy      = busy_r;
   assign ready     = ready_r;
   assign init_done = init_done_r;
   assign rd_valid  = rd_valid_r;
   assign err_oob   = err_oob_r;

endmodule

// File: tb/tb_direction_ram_ctrl.sv
// Self-checking bench for direction_ram_ctrl with LEN_A=4, LEN_B=3.
// Directed table, init/reset sequences and a randomized phase checked
// against a cell-array reference model.
module tb_direction_ram_ctrl;

   localparam int LA = 4;
   localparam int LB = 3;
`ifdef RD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       start_init;
   logic       busy, ready, init_done;
   logic       wr_en;
   logic [2:0] wr_i;
   logic [1:0] wr_j;
   logic [2:0] wr_dir;
   logic       rd_en;
   logic [2:0] rd_i;
   logic [1:0] rd_j;
   logic [2:0] rd_dir;
   logic       rd_valid, err_oob;

   int errors = 0;
   int checks = 0;

   // reference model state
   int ref_mem [LA+1][LB+1];
   bit m_ready = 1'b0;
   bit m_err   = 1'b0;
   bit m_valid = 1'b0;
   int m_dir   = 0;

   typedef struct {
      bit we; int wi; int wj; int wd;
      bit re; int ri; int rj;
      bit ev; int ed; bit ee;
   } vec_t;
   vec_t tbl [14];

   direction_ram_ctrl #(.LEN_A(LA), .LEN_B(LB), .DIR_W(3)) dut (
      .clk(clk), .rst(rst), .start_init(start_init),
      .busy(busy), .ready(ready), .init_done(init_done),
      .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_dir(wr_dir),
      .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j),
      .rd_dir(rd_dir), .rd_valid(rd_valid), .err_oob(err_oob)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access cycle: drive ports, advance the model, clock the DUT.
   task automatic cycle(input bit we, input int wi, input int wj, input int wd,
                        input bit re, input int ri, input int rj);
      bit wok, rok;
      wr_en = we; wr_i = 3'(wi); wr_j = 2'(wj); wr_dir = 3'(wd);
      rd_en = re; rd_i = 3'(ri); rd_j = 2'(rj);
      wok = m_ready && we && wi >= 1 && wi <= LA && wj >= 1 && wj <= LB;
      rok = m_ready && re && ri >= 0 && ri <= LA && rj >= 0 && rj <= LB;
      m_valid = rok;
      if (rok) begin
         if (FWD && wok && wi == ri && wj == rj) m_dir = wd;
         else m_dir = ref_mem[ri][rj];
      end
      if ((we && !wok) || (re && !rok)) m_err = 1'b1;
      if (wok) ref_mem[wi][wj] = wd;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
   endtask

   // Start an init and follow it to READY, optionally re-pulsing start_init
   // or issuing a read at a given busy cycle.
   task automatic run_init(input int restart_at, input int read_at,
                           output int bcnt, output int dcnt);
      bit got;
      bcnt = 0; dcnt = 0; got = 1'b0;
      start_init = 1'b1;
      tick();
      start_init = 1'b0;
      m_ready = 1'b0; m_err = 1'b0;
      check("err_cleared_by_start", err_oob, 0);
      for (int k = 0; k < 40; k++) begin
         if (busy) bcnt++;
         if (init_done) dcnt++;
         if (ready) begin
            got = 1'b1;
            check("init_done_first_ready", init_done, 1);
            break;
         end
         if (k == restart_at) start_init = 1'b1;
         if (k == read_at) begin
            rd_en = 1'b1; rd_i = 3'd0; rd_j = 2'd0;
            m_err = 1'b1;
         end
         tick();
         start_init = 1'b0;
         if (k == read_at) begin
            rd_en = 1'b0;
            check("rd_valid_during_init", rd_valid, 0);
            check("err_rd_during_init", err_oob, 1);
         end
      end
      check("init_reached_ready", got, 1);
      m_ready = 1'b1;
      for (int j = 0; j <= LB; j++) ref_mem[0][j] = (j == 0) ? 0 : 4;
      for (int i = 1; i <= LA; i++) ref_mem[i][0] = 2;
      check("err_after_init", err_oob, m_err);
   endtask

   initial begin
      int bc, dc;
      rst = 1'b0; start_init = 1'b0;
      wr_en = 1'b0; wr_i = '0; wr_j = '0; wr_dir = '0;
      rd_en = 1'b0; rd_i = '0; rd_j = '0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_ready", ready, 0);
      check("rst_init_done", init_done, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_err", err_oob, 0);
      check("rst_rd_dir", rd_dir, 0);
      rst = 1'b1;
      tick();

      // first init: busy for LB+1+LA cycles, one done pulse
      run_init(-1, -1, bc, dc);
      check("init1_busy_cycles", bc, LB + 1 + LA);
      check("init1_done_pulses", dc, 1);
      check("init1_ready", ready, 1);
      tick();
      check("init_done_one_cycle", init_done, 0);
      check("ready_holds", ready, 1);

      // seed every interior cell so later reads have known contents
      for (int i = 1; i <= LA; i++)
         for (int j = 1; j <= LB; j++) begin
            cycle(1'b1, i, j, (i * 3 + j) % 8, 1'b0, 0, 0);
            check("fill_no_err", err_oob, 0);
         end

      // directed table: {we,wi,wj,wd, re,ri,rj, exp valid,dir,err}
      tbl[0]  = '{0,0,0,0, 1,0,0, 1,0,0};
      tbl[1]  = '{0,0,0,0, 1,0,2, 1,4,0};
      tbl[2]  = '{0,0,0,0, 1,3,0, 1,2,0};
      tbl[3]  = '{1,2,3,1, 0,0,0, 0,2,0};
      tbl[4]  = '{0,0,0,0, 1,2,3, 1,1,0};
      tbl[5]  = '{1,2,2,5, 0,0,0, 0,1,0};
      tbl[6]  = '{0,0,0,0, 1,2,2, 1,5,0};
      tbl[7]  = '{1,1,1,3, 0,0,0, 0,5,0};
      tbl[8]  = '{1,1,1,4, 1,1,1, 1,(FWD ? 4 : 3),0};
      tbl[9]  = '{0,0,0,0, 1,1,1, 1,4,0};
      tbl[10] = '{1,0,2,1, 0,0,0, 0,4,1};
      tbl[11] = '{0,0,0,0, 1,0,2, 1,4,1};
      tbl[12] = '{1,5,1,2, 0,0,0, 0,4,1};
      tbl[13] = '{0,0,0,0, 1,5,3, 0,4,1};
      for (int n = 0; n < 14; n++) begin
         cycle(tbl[n].we, tbl[n].wi, tbl[n].wj, tbl[n].wd,
               tbl[n].re, tbl[n].ri, tbl[n].rj);
         check($sformatf("tbl%0d_rd_valid", n), rd_valid, tbl[n].ev);
         check($sformatf("tbl%0d_rd_dir", n), rd_dir, tbl[n].ed);
         check($sformatf("tbl%0d_err", n), err_oob, tbl[n].ee);
      end

      // re-init clears err, read during busy sets it again, ignored restart
      run_init(3, 2, bc, dc);
      check("init2_busy_cycles", bc, LB + 1 + LA);
      check("init2_done_pulses", dc, 1);
      check("init2_err_set", err_oob, 1);
      check("interior_kept", ref_mem[2][2], 5);
      cycle(1'b0, 0, 0, 0, 1'b1, 2, 2);
      check("interior_after_reinit", rd_dir, 5);

      // clean init, then randomized traffic against the model
      run_init(-1, -1, bc, dc);
      check("init3_err_clear", err_oob, 0);
      for (int n = 0; n < 400; n++) begin
         int wi, wj, ri, rj;
         bit collide;
         collide = ($urandom_range(0, 7) == 0);
         wi = $urandom_range(0, 5); wj = $urandom_range(0, 3);
         ri = collide ? wi : $urandom_range(0, 5);
         rj = collide ? wj : $urandom_range(0, 3);
         cycle(1'($urandom_range(0, 1)), wi, wj, $urandom_range(0, 7),
               1'($urandom_range(0, 1)), ri, rj);
         check("rnd_rd_valid", rd_valid, m_valid);
         check("rnd_rd_dir", rd_dir, m_dir);
         check("rnd_err", err_oob, m_err);
      end

      // reset mid-init aborts everything
      start_init = 1'b1;
      tick();
      start_init = 1'b0;
      tick();
      tick();
      check("midinit_busy_before_rst", busy, 1);
      rst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_ready", ready, 0);
      check("midrst_init_done", init_done, 0);
      check("midrst_rd_valid", rd_valid, 0);
      check("midrst_err", err_oob, 0);
      check("midrst_rd_dir", rd_dir, 0);
      #2;
      rst = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         check("after_rst_idle_busy", busy, 0);
         check("after_rst_idle_ready", ready, 0);
      end
      m_ready = 1'b0; m_err = 1'b0;
      cycle(1'b0, 0, 0, 0, 1'b1, 0, 0);
      check("idle_read_dropped", rd_valid, 0);
      check("idle_read_err", err_oob, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
